// File: rtl/gf_op_scheduler.sv
// Microcode sequencer for the GF(2^m) ECC datapath: fetch, decode and issue with a
// per-register scoreboard. Optional stall counter built when STALL_CNT_EN is defined.
module gf_op_scheduler #(
  parameter int OP_W    = 32,
  parameter int PC_W    = 6,
  parameter int MUL_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PC_W-1:0] cmd_base,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [PC_W-1:0] uop_addr,
  input  logic [OP_W-1:0] uop_data,
  input  logic            core2_busy,
  output logic            issue_valid,
  output logic [OP_W-1:0] issue_op,
  output logic [15:0]     stall_cycles
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, DRAIN} state_t;

  state_t                     state;
  logic [PC_W-1:0]            pc;
  logic [OP_W-1:0]            uop_reg;
  logic [7:0][CNT_W-1:0]      sb;

  logic       is_mul, last, hazard, fire, sb_idle;
  logic [2:0] dst, srca, srcb;

  assign is_mul = uop_reg[0];
  assign dst    = uop_reg[3:1];
  assign srca   = uop_reg[6:4];
  assign srcb   = uop_reg[9:7];
  assign last   = uop_reg[10];

  // A counter at 1 is in the cycle its producer's result lands, which the
  // datapath forwards, so only counts above 1 block a dependent issue.
  function automatic logic reg_pending(input logic [2:0] r, input logic [7:0][CNT_W-1:0] s);
    return (r != 3'd0) && (s[r] > CNT_W'(1));
  endfunction

  assign hazard = reg_pending(srca, sb) || reg_pending(srcb, sb) || reg_pending(dst, sb) ||
                  (is_mul && core2_busy);
  assign fire   = (state == ISSUE) && !hazard;
  assign sb_idle = (sb == '0);

  assign issue_valid = fire;
  assign issue_op    = fire ? uop_reg : '0;
  assign done        = (state == DRAIN) && sb_idle;
  assign uop_addr    = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      uop_reg <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pc    <= cmd_base;
          err   <= 1'b0;
          busy  <= 1'b1;
          state <= FETCH;
        end
        FETCH:  state <= DECODE;
        DECODE: begin
          uop_reg <= uop_data;
          state   <= ISSUE;
        end
        ISSUE: if (!hazard) begin
          if (last) state <= DRAIN;
          else begin
            if (pc == '1) err <= 1'b1;
            pc    <= pc + 1'b1;
            state <= FETCH;
          end
        end
        DRAIN: if (sb_idle) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issue reload beats the per-cycle decrement; reg 0 is never loaded so stays 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (fire && dst != 3'd0 && dst == 3'(i))
          sb[i] <= is_mul ? CNT_W'(MUL_LAT) : CNT_W'(1);
        else if (sb[i] != '0)
          sb[i] <= sb[i] - 1'b1;
      end
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (state == IDLE && start)
      stall_cycles <= '0;
    else if (state == ISSUE && hazard && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 1'b1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_gf_op_scheduler.sv
// Directed bench for gf_op_scheduler: an op-level timing model predicts every issue
// cycle, the done cycle, err and the stall total; a per-cycle compare checks the DUT.
module tb_gf_op_scheduler;
  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst, start, core2_busy;
  logic [5:0]  cmd_base, uop_addr;
  logic [31:0] uop_data, issue_op;
  logic        busy, done, err, issue_valid;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  gf_op_scheduler #(.OP_W(32), .PC_W(6), .MUL_LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_base(cmd_base), .busy(busy), .done(done),
    .err(err), .uop_addr(uop_addr), .uop_data(uop_data), .core2_busy(core2_busy),
    .issue_valid(issue_valid), .issue_op(issue_op), .stall_cycles(stall_cycles)
  );

  logic [31:0] rom [64];
  always @(posedge clk) uop_data <= rom[uop_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input bit mul, input int d, input int a, input int b,
                                     input bit last, input logic [20:0] p);
    return {p, last, 3'(b), 3'(a), 3'(d), mul};
  endfunction

  // Model: per-register "free from" cycle, core2_busy window, all relative to start.
  bit          exp_v [256];
  logic [31:0] exp_op [256];
  int          rh [8];
  int          m_issue [$];
  int          m_done, m_stall;
  bit          m_err;
  int          blo = 0, bhi = 0;
  int          s = 1000000;
  bit          chk_on = 1'b0;

  function automatic bit hz(input logic [31:0] op, input int c);
    int d, a, b;
    d = int'(op[3:1]); a = int'(op[6:4]); b = int'(op[9:7]);
    return (d != 0 && c < rh[d]) || (a != 0 && c < rh[a]) || (b != 0 && c < rh[b]) ||
           (op[0] && c >= blo && c < bhi);
  endfunction

  task automatic build_model(input logic [5:0] base);
    logic [5:0]  pc;
    logic [31:0] op;
    int t, c, d;
    foreach (rh[i]) rh[i] = 0;
    foreach (exp_v[i]) exp_v[i] = 1'b0;
    m_issue.delete();
    m_err = 1'b0; m_stall = 0; m_done = -1;
    pc = base; t = 3;
    for (int n = 0; n < 64; n++) begin
      op = rom[pc];
      c = t;
      while (c < 250 && hz(op, c)) c++;
      m_stall += c - t;
      exp_v[c] = 1'b1; exp_op[c] = op;
      m_issue.push_back(c);
      d = int'(op[3:1]);
      if (d != 0) rh[d] = c + (op[0] ? LAT : 1);
      if (op[10]) begin
        m_done = c + 1;
        foreach (rh[i]) if (rh[i] + 1 > m_done) m_done = rh[i] + 1;
        break;
      end
      if (pc == 6'd63) m_err = 1'b1;
      pc = pc + 6'd1;
      t = c + 3;
    end
  endtask

  int rel_c;
  always @(negedge clk) begin
    if (chk_on) begin
      rel_c = cyc - s;
      if (rel_c >= 0 && rel_c < 256) begin
        chk($sformatf("issue_valid@%0d", rel_c), 32'(issue_valid), 32'(exp_v[rel_c]));
        if (exp_v[rel_c]) chk($sformatf("issue_op@%0d", rel_c), issue_op, exp_op[rel_c]);
        chk($sformatf("done@%0d", rel_c), 32'(done), 32'(rel_c == m_done));
        chk($sformatf("busy@%0d", rel_c), 32'(busy), 32'(rel_c >= 1 && rel_c <= m_done));
      end
    end
  end

  initial begin
    core2_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      core2_busy = chk_on && (cyc - s) >= blo && (cyc - s) < bhi;
    end
  end

  task automatic run_cmd(input logic [5:0] base, input int lo, input int hi, input int spur);
    blo = lo; bhi = hi;
    build_model(base);
    @(posedge clk); #1;
    s = cyc; cmd_base = base; start = 1'b1; chk_on = 1'b1;
    for (int k = 1; k <= m_done + 2; k++) begin
      @(posedge clk); #1;
      start    = (k == spur);
      cmd_base = (k == spur) ? 6'd20 : base;
    end
    chk_on = 1'b0; start = 1'b0;
    chk("err", 32'(err), 32'(m_err));
`ifdef STALL_CNT_EN
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`else
    chk("stall_cycles", 32'(stall_cycles), 32'd0);
`endif
  endtask

  initial begin
    foreach (rom[i]) rom[i] = '0;
    rst = 1'b1; start = 1'b0; cmd_base = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_issue_op", issue_op, 0);
    chk("rst_uop_addr", 32'(uop_addr), 0);
    chk("rst_stall", 32'(stall_cycles), 0);
    rst = 1'b0;

    // back-to-back independent core1 ops
    rom[0] = mk(0, 1, 0, 0, 0, 21'h1A5A5);
    rom[1] = mk(0, 2, 0, 0, 1, 21'h0F00F);
    run_cmd(6'd0, 0, 0, -1);
    chk("model_t1_issue0", 32'(m_issue[0]), 3);
    chk("model_t1_issue1", 32'(m_issue[1]), 6);
    chk("model_t1_done", 32'(m_done), 8);
    chk("model_t1_stall", 32'(m_stall), 0);

    // mul RAW hazard
    rom[2] = mk(1, 3, 0, 0, 0, 21'h12345);
    rom[3] = mk(0, 1, 3, 0, 1, 21'h0ABCD);
    run_cmd(6'd2, 0, 0, -1);
    chk("model_t2_gap", 32'(m_issue[1] - m_issue[0]), 8);
    chk("model_t2_stall", 32'(m_stall), 5);

    // core2_busy held 10 cycles over a mul
    rom[4] = mk(1, 4, 1, 2, 1, 21'h1FFFF);
    run_cmd(6'd4, 2, 12, -1);
    chk("model_t3_issue", 32'(m_issue[0]), 12);

    // PC wrap 63 -> 0
    rom[63] = mk(0, 5, 0, 0, 0, 21'h00063);
    rom[0]  = mk(0, 1, 5, 0, 1, 21'h00100);
    run_cmd(6'd63, 0, 0, -1);
    chk("model_t4_err", 32'(m_err), 1);

    // reset during DRAIN while reg 3 is still pending
    rom[0] = mk(1, 3, 0, 0, 1, 21'h0C0DE);
    rom[1] = mk(0, 1, 3, 0, 1, 21'h0BEEF);
    @(posedge clk); #1;
    cmd_base = 6'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_issue_valid", 32'(issue_valid), 0);
    chk("abort_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_abort_quiet", 32'({issue_valid, done}), 0);
    end
    run_cmd(6'd1, 0, 0, -1);

    // start while busy is ignored
    rom[5]  = mk(0, 1, 0, 0, 0, 21'h00055);
    rom[6]  = mk(0, 2, 1, 0, 1, 21'h00066);
    rom[20] = mk(0, 7, 0, 0, 1, 21'h1D1D1);
    run_cmd(6'd5, 0, 0, 4);

    // WAW plus srcB hazard, then a temp-FIFO consumer
    rom[8]  = mk(1, 2, 0, 0, 0, 21'h00808);
    rom[9]  = mk(0, 6, 4, 2, 0, 21'h00909);
    rom[10] = mk(0, 2, 6, 0, 1, 21'h00A0A);
    run_cmd(6'd8, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end
endmodule
